// File: rtl/param_computer.sv
// Multi-cycle register CPU: req/ack instruction fetch, parametrised register file,
// flag-driven jumps and strobed output ports.
module param_computer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned REG_AW     = 2,
    parameter int unsigned PC_W       = 8,
    parameter int unsigned NUM_OPORTS = 2,
    localparam int unsigned INSTR_W   = 4 + 2*REG_AW + DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [PC_W-1:0]              imem_addr,
    input  logic                         imem_ack,
    input  logic [INSTR_W-1:0]           imem_data,
    input  logic [DATA_W-1:0]            iport,
    output logic [NUM_OPORTS*DATA_W-1:0] oport,
    output logic [NUM_OPORTS-1:0]        oport_stb,
    output logic                         halted,
    output logic [1:0]                   state
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALT   = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,  OP_LDI = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3,
        OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_SHL = 4'd7,
        OP_SHR = 4'd8,  OP_OUT = 4'd9,  OP_IN  = 4'd10, OP_JMP = 4'd11,
        OP_JZ  = 4'd12, OP_JC  = 4'd13, OP_CMP = 4'd14, OP_HLT = 4'd15
    } op_e;

    state_e                      state_q;
    logic [PC_W-1:0]             pc_q;
    logic [INSTR_W-1:0]          instr_q;
    logic [DATA_W-1:0]           op1_q;
    logic [DATA_W-1:0]           op2_q;
    logic [DATA_W-1:0]           regs_q [2**REG_AW];
    logic                        z_q;
    logic                        c_q;
    logic                        halted_q;
    logic [NUM_OPORTS*DATA_W-1:0] oport_q;
    logic [NUM_OPORTS-1:0]       stb_q;

    op_e                         opcode;
    logic [REG_AW-1:0]           ra;
    logic [REG_AW-1:0]           rb;
    logic [DATA_W-1:0]           imm;

    assign opcode = op_e'(instr_q[INSTR_W-1 -: 4]);
    assign ra     = instr_q[DATA_W+REG_AW +: REG_AW];
    assign rb     = instr_q[DATA_W +: REG_AW];
    assign imm    = instr_q[DATA_W-1:0];

    // Result and carry share one extended word: bit DATA_W is the flag C.
    logic [DATA_W:0]   wide_d;
    logic [DATA_W-1:0] res_d;
    logic              c_d;
    logic              flags_d;
    logic              wr_d;
    logic              taken_d;

    always_comb begin
        wide_d  = '0;
        flags_d = 1'b1;
        wr_d    = 1'b1;
        case (opcode)
            OP_ADD:         wide_d = {1'b0, op1_q} + {1'b0, op2_q};
            OP_SUB, OP_CMP: wide_d = {1'b0, op1_q} - {1'b0, op2_q};
            OP_AND:         wide_d = {1'b0, op1_q & op2_q};
            OP_OR:          wide_d = {1'b0, op1_q | op2_q};
            OP_XOR:         wide_d = {1'b0, op1_q ^ op2_q};
            OP_SHL:         wide_d = {op1_q, 1'b0};
            OP_SHR:         wide_d = {op1_q[0], 1'b0, op1_q[DATA_W-1:1]};
            OP_LDI: begin
                wide_d  = {1'b0, imm};
                flags_d = 1'b0;
            end
            OP_IN: begin
                wide_d  = {1'b0, iport};
                flags_d = 1'b0;
            end
            default: begin
                flags_d = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
        if (opcode == OP_CMP) wr_d = 1'b0;
        res_d   = wide_d[DATA_W-1:0];
        c_d     = wide_d[DATA_W];
        taken_d = (opcode == OP_JMP) || (opcode == OP_JZ && z_q) || (opcode == OP_JC && c_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            instr_q  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            halted_q <= 1'b0;
            oport_q  <= '0;
            stb_q    <= '0;
            for (int unsigned i = 0; i < 2**REG_AW; i++) regs_q[i] <= '0;
        end else begin
            stb_q <= '0;
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_data;
                        pc_q    <= pc_q + PC_W'(1);
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    op1_q   <= regs_q[ra];
                    op2_q   <= regs_q[rb];
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (wr_d) regs_q[ra] <= res_d;
                    if (flags_d) begin
                        z_q <= (res_d == '0);
                        c_q <= c_d;
                    end
                    if (taken_d) pc_q <= PC_W'(imm);
                    // Port indices at or beyond NUM_OPORTS match no k and fall through silently.
                    if (opcode == OP_OUT) begin
                        for (int unsigned k = 0; k < NUM_OPORTS; k++) begin
                            if (imm == DATA_W'(k)) begin
                                oport_q[k*DATA_W +: DATA_W] <= op1_q;
                                stb_q[k]                    <= 1'b1;
                            end
                        end
                    end
                    if (opcode == OP_HLT) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                HALT: halted_q <= 1'b1;
            endcase
        end
    end

    // Request is masked by reset so a pending fetch drops in the reset cycle itself.
    assign imem_req  = (state_q == FETCH) && !reset;
    assign imem_addr = pc_q;
    assign oport     = oport_q;
    assign oport_stb = stb_q;
    assign halted    = halted_q;
    assign state     = state_q;

endmodule

// File: tb/tb_param_computer.sv
// Directed and randomised checks of param_computer against an instruction-level model.
module tb_param_computer;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int PW = 3;
    localparam int NP = 2;
    localparam int IW = 4 + 2*AW + DW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           imem_req;
    logic [PW-1:0]  imem_addr;
    logic           imem_ack;
    logic [IW-1:0]  imem_data;
    logic [DW-1:0]  iport = '0;
    logic [NP*DW-1:0] oport;
    logic [NP-1:0]  oport_stb;
    logic           halted;
    logic [1:0]     state;

    logic [IW-1:0]  prog [8];
    logic           ack_en = 1'b1;
    bit             mon_en = 1'b0;

    int checks = 0;
    int passed = 0;

    int obs_port[$];
    int obs_val[$];
    int exp_port[$];
    int exp_val[$];

    param_computer #(.DATA_W(DW), .REG_AW(AW), .PC_W(PW), .NUM_OPORTS(NP)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .iport(iport), .oport(oport),
        .oport_stb(oport_stb), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    assign imem_data = prog[imem_addr];
    assign imem_ack  = imem_req && ack_en;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            for (int k = 0; k < NP; k++) begin
                if (oport_stb[k]) begin
                    obs_port.push_back(k);
                    obs_val.push_back(int'(oport[k*DW +: DW]));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [IW-1:0] enc(input int op, input int a, input int b, input int im);
        logic [3:0] o = 4'(op);
        logic [1:0] x = 2'(a);
        logic [1:0] y = 2'(b);
        logic [7:0] i = 8'(im);
        return {o, x, y, i};
    endfunction

    task automatic load(input logic [IW-1:0] p [8]);
        for (int i = 0; i < 8; i++) prog[i] = p[i];
    endtask

    // Instruction-level reference: runs up to kmax instructions and records port writes.
    task automatic model_run(input int kmax, output int n, output bit mh, output int mpc);
        int r [4];
        int z, c, pc, op, a, b, im, x, y, t;
        bit fl;
        logic [IW-1:0] w;
        for (int i = 0; i < 4; i++) r[i] = 0;
        z = 0; c = 0; pc = 0; mh = 0; n = 0;
        exp_port.delete();
        exp_val.delete();
        while (n < kmax && !mh) begin
            w  = prog[pc];
            op = int'(w[15:12]); a = int'(w[11:10]); b = int'(w[9:8]); im = int'(w[7:0]);
            pc = (pc + 1) % 8;
            n++;
            x = r[a]; y = r[b]; t = 0; fl = 0;
            case (op)
                1:  r[a] = im;
                2:  begin t = x + y; c = (t > 255) ? 1 : 0; fl = 1; r[a] = t % 256; end
                3:  begin t = (x - y + 256) % 256; c = (x < y) ? 1 : 0; fl = 1; r[a] = t; end
                4:  begin t = x & y; c = 0; fl = 1; r[a] = t; end
                5:  begin t = x | y; c = 0; fl = 1; r[a] = t; end
                6:  begin t = x ^ y; c = 0; fl = 1; r[a] = t; end
                7:  begin t = (x * 2) % 256; c = x / 128; fl = 1; r[a] = t; end
                8:  begin t = x / 2; c = x % 2; fl = 1; r[a] = t; end
                9:  if (im < NP) begin exp_port.push_back(im); exp_val.push_back(x); end
                10: r[a] = int'(iport);
                11: pc = im % 8;
                12: if (z == 1) pc = im % 8;
                13: if (c == 1) pc = im % 8;
                14: begin t = (x - y + 256) % 256; c = (x < y) ? 1 : 0; fl = 1; end
                15: mh = 1;
                default: ;
            endcase
            if (fl) z = (t == 0) ? 1 : 0;
        end
        mpc = pc;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        ack_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        obs_port.delete();
        obs_val.delete();
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic compare_queues(input string tag);
        check({tag, " strobe count"}, 32'(obs_port.size()), 32'(exp_port.size()));
        for (int i = 0; i < obs_port.size() && i < exp_port.size(); i++) begin
            check($sformatf("%s port[%0d]", tag, i), 32'(obs_port[i]), 32'(exp_port[i]));
            check($sformatf("%s value[%0d]", tag, i), 32'(obs_val[i]), 32'(exp_val[i]));
        end
    endtask

    // Releases reset, runs kmax instruction slots (3 cycles each), compares against the model.
    task automatic run_and_compare(input string tag, input int kmax);
        int n, mpc;
        bit mh;
        model_run(kmax, n, mh, mpc);
        do_reset();
        repeat (3*kmax) @(posedge clk);
        @(negedge clk); #1;
        compare_queues(tag);
        check({tag, " halted"}, 32'(halted), 32'(mh));
        if (mh) begin
            check({tag, " state"}, 32'(state), 32'd3);
            check({tag, " req"}, 32'(imem_req), 32'd0);
        end else begin
            check({tag, " state"}, 32'(state), 32'd0);
            check({tag, " pc"}, 32'(imem_addr), 32'(mpc));
        end
    endtask

    initial begin
        logic [IW-1:0] p [8];

        // Reset and first fetch
        for (int i = 0; i < 8; i++) p[i] = enc(0, 0, 0, 0);
        load(p);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req", 32'(imem_req), 32'd0);
        check("reset state", 32'(state), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("first req", 32'(imem_req), 32'd1);
        check("first addr", 32'(imem_addr), 32'd0);
        check("first oport", 32'(oport), 32'd0);
        check("first stb", 32'(oport_stb), 32'd0);
        check("first state", 32'(state), 32'd0);
        check("first halted", 32'(halted), 32'd0);

        // LDI/ADD carry and JC
        p[0] = enc(1, 0, 0, 200); p[1] = enc(1, 1, 0, 100); p[2] = enc(2, 0, 1, 0);
        p[3] = enc(13, 0, 0, 6);  p[4] = enc(9, 1, 0, 0);   p[5] = enc(15, 0, 0, 0);
        p[6] = enc(9, 0, 0, 1);   p[7] = enc(15, 0, 0, 0);
        load(p);
        run_and_compare("addjc", 8);
        check("addjc port1", 32'(oport[DW +: DW]), 32'd44);
        check("addjc port0", 32'(oport[0 +: DW]), 32'd0);
        check("addjc pulses", 32'(obs_port.size()), 32'd1);

        // Countdown loop with JZ
        p[0] = enc(1, 0, 0, 3); p[1] = enc(1, 1, 0, 1); p[2] = enc(3, 0, 1, 0);
        p[3] = enc(9, 0, 0, 0); p[4] = enc(12, 0, 0, 6); p[5] = enc(11, 0, 0, 2);
        p[6] = enc(15, 0, 0, 0); p[7] = enc(0, 0, 0, 0);
        load(p);
        run_and_compare("loop", 20);
        check("loop n", 32'(obs_val.size()), 32'd3);
        if (obs_val.size() == 3) begin
            check("loop v0", 32'(obs_val[0]), 32'd2);
            check("loop v1", 32'(obs_val[1]), 32'd1);
            check("loop v2", 32'(obs_val[2]), 32'd0);
        end

        // Ack stall on the second fetch
        p[0] = enc(1, 2, 0, 8'h5A); p[1] = enc(9, 2, 0, 0); p[2] = enc(15, 0, 0, 0);
        for (int i = 3; i < 8; i++) p[i] = enc(0, 0, 0, 0);
        load(p);
        do_reset();
        @(posedge clk); #1;
        ack_en = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall addr %0d", i), 32'(imem_addr), 32'd1);
            check($sformatf("stall state %0d", i), 32'(state), 32'd0);
            check($sformatf("stall req %0d", i), 32'(imem_req), 32'd1);
        end
        ack_en = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        check("stall port0", 32'(oport[0 +: DW]), 32'h5A);
        check("stall pulses", 32'(obs_port.size()), 32'd1);
        check("stall halted", 32'(halted), 32'd1);

        // Out-of-range port
        p[0] = enc(1, 0, 0, 9); p[1] = enc(9, 0, 0, 5); p[2] = enc(15, 0, 0, 0);
        load(p);
        run_and_compare("oor", 5);
        check("oor oport", 32'(oport), 32'd0);

        // PC wrap through 8 NOPs
        for (int i = 0; i < 8; i++) p[i] = enc(0, 0, 0, 0);
        load(p);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("wrap addr %0d", i), 32'(imem_addr), 32'(i % 8));
            check($sformatf("wrap state %0d", i), 32'(state), 32'd0);
            repeat (3) @(posedge clk);
        end

        // Reset during EXEC of an OUT, then during HALT
        p[0] = enc(1, 0, 0, 7); p[1] = enc(9, 0, 0, 0); p[2] = enc(15, 0, 0, 0);
        load(p);
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        check("midexec state", 32'(state), 32'd2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midexec stb", 32'(oport_stb), 32'd0);
        check("midexec oport", 32'(oport), 32'd0);
        check("midexec req", 32'(imem_req), 32'd0);
        check("midexec state0", 32'(state), 32'd0);
        check("midexec halted", 32'(halted), 32'd0);
        check("midexec pulses", 32'(obs_port.size()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("restart addr", 32'(imem_addr), 32'd0);
        check("restart req", 32'(imem_req), 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        check("restart port0", 32'(oport[0 +: DW]), 32'd7);
        check("restart halted", 32'(halted), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("halt rst halted", 32'(halted), 32'd0);
        check("halt rst req", 32'(imem_req), 32'd0);
        check("halt rst state", 32'(state), 32'd0);
        check("halt rst oport", 32'(oport), 32'd0);
        check("halt rst stb", 32'(oport_stb), 32'd0);

        // Random programs against the model
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 8; i++) begin
                int op, im;
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 3) != 0) op = 9;
                im = (op == 9) ? $urandom_range(0, 3) : $urandom_range(0, 255);
                p[i] = enc(op, $urandom_range(0, 3), $urandom_range(0, 3), im);
            end
            load(p);
            iport = 8'($urandom_range(0, 255));
            run_and_compare($sformatf("rand%0d", t), 30);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/param_computer.md
# param_computer

Parametrised multi-cycle register CPU, the successor to the fixed 8-bit single-port `computer`. It fetches instructions over a req/ack memory handshake and executes them on a register file of configurable width and depth. Results drive several strobed output ports. It is the processing core instantiated at system top level, with the program store external to it.

## Interface
Parameters:
- `DATA_W`, default 8: register, ALU, immediate and port data width (≥4).
- `REG_AW`, default 2: register address bits; the block has 2**REG_AW registers.
- `PC_W`, default 8: program counter / instruction address width.
- `NUM_OPORTS`, default 2: number of output ports (1..2**DATA_W).
- Derived: `INSTR_W = 4 + 2*REG_AW + DATA_W`.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  PC_W: fetch address (current pc).
- `imem_ack`  in  1: fetch data valid this cycle.
- `imem_data`  in  INSTR_W: instruction word `{opcode[3:0], ra[REG_AW], rb[REG_AW], imm[DATA_W]}`, MSB first.
- `iport`  in  DATA_W: input port, sampled by IN.
- `oport`  out  NUM_OPORTS*DATA_W: output port registers; port k is at bits [k*DATA_W +: DATA_W].
- `oport_stb`  out  NUM_OPORTS: one-cycle write pulse per port.
- `halted`  out  1: high once HLT has executed.
- `state`  out  2: FSM state for debug, with FETCH=0, DECODE=1, EXEC=2, HALT=3.

## Operation
- FSM states:
  - FETCH: drive `imem_req=1`, `imem_addr=pc`. On `imem_ack`, latch `instruction`, set pc ← pc+1 (mod 2**PC_W), then go to DECODE. Otherwise stay in FETCH.
  - DECODE: latch `operand_1=R[ra]`, `operand_2=R[rb]`, then go to EXEC.
  - EXEC: perform the operation, then go to FETCH. HLT goes to HALT instead.
  - HALT: terminal; leaves only by `reset`.
- Opcodes:
  - 0 NOP.
  - 1 LDI: R[ra] ← imm.
  - 2 ADD: R[ra] ← op1+op2.
  - 3 SUB: R[ra] ← op1−op2.
  - 4 AND, 5 OR, 6 XOR: R[ra] ← op1 op op2.
  - 7 SHL: R[ra] ← op1<<1.
  - 8 SHR: R[ra] ← op1>>1, logical.
  - 9 OUT: port[imm] ← op1.
  - 10 IN: R[ra] ← iport.
  - 11 JMP: pc ← imm[PC_W-1:0], zero-extended if PC_W > DATA_W.
  - 12 JZ: jump as JMP if Z=1.
  - 13 JC: jump as JMP if C=1.
  - 14 CMP: flags only, from op1−op2.
  - 15 HLT.
- Arithmetic is modulo 2**DATA_W.
- Flags:
  - Z = (result==0) and C are updated only by opcodes 2–8 and 14.
  - ADD: C = carry-out.
  - SUB/CMP: C = borrow (op1<op2).
  - SHL: C = old MSB. SHR: C = old LSB.
  - AND/OR/XOR clear C.
  - LDI, IN, OUT, jumps and NOP leave flags unchanged.
- OUT with imm ≥ NUM_OPORTS is a no-op: no port change, no strobe.
- OUT to port k: `oport[k]` updates at the end of EXEC and `oport_stb[k]` is high for exactly the following cycle. `oport[k]` then holds its value until the next OUT to port k.
- Operands are latched in DECODE, so `ADD r1,r1` uses the pre-instruction value of r1.

## Timing
- Reset values:
  - pc=0, all registers 0, Z=C=0.
  - `oport`=0, `oport_stb`=0.
  - `halted`=0, `state`=FETCH, `imem_req`=0 in the reset cycle.
  - `imem_req`=1 from the first cycle after `reset` deasserts.
- Latency: with `imem_ack` returned in the same cycle as the request, each instruction takes exactly 3 cycles. Each cycle of ack delay adds one cycle.
- `imem_addr` is stable while `imem_req` is high and ack has not arrived.
- `imem_ack` outside FETCH is ignored.
- `imem_req` is low in DECODE, EXEC and HALT.
- In the HALT state, `halted` rises on the first cycle and stays high. `imem_req` stays 0 and there are no further strobes.
- A taken jump sets pc in EXEC, and the next FETCH uses the new pc.
- pc wraps: executing the instruction at address 2**PC_W−1 fetches address 0 next.
- Reset during any state, including mid-fetch and HALT, returns all state to reset values on that edge. A pending fetch is abandoned and `imem_req` is 0 in the next cycle.

## Test plan
- Reset / first fetch: hold `reset` 2 cycles, then release. Required: `imem_req`=1 and `imem_addr`=0 on the next cycle, all `oport`=0, `state`=0.
- LDI/ADD/OUT with DATA_W=8: program LDI r0,200; LDI r1,100; ADD r0,r1; JC 6; OUT r1,0; HLT; OUT r0,1; HLT. Required:
  - port1=44 with `oport_stb[1]` pulsing once;
  - port0 untouched;
  - `halted`=1.
- Flags/loop: LDI r0,3; LDI r1,1; SUB r0,r1; OUT r0,0; JZ 6; JMP 2; HLT. Required: port0 strobes 2,1,0 in order, then halts.
- Ack stall: hold `imem_ack` low 5 cycles on one fetch. Required: `imem_addr` is constant, the FSM stays in FETCH, and the instruction executes correctly afterwards.
- Out-of-range port and wrap, with PC_W=3, NUM_OPORTS=2:
  - OUT to port 5: no strobe, no change.
  - Program of 8 NOPs: address sequence 0..7, 0.
- Reset mid-operation: assert `reset` during EXEC of an OUT and again while in HALT. Required: no strobe, every output at its reset value, execution restarts at pc=0.
